// File: rtl/paddle_pulse_decoder_if.sv
// rtl/paddle_pulse_decoder_if.sv - paddle decoder signal bundle (core/pin inputs, position outputs)
interface paddle_pulse_decoder_if #(
    parameter int CNT_W = 8
);
    logic             hsync;
    logic             pad_en_n;
    logic             pad_in;
    logic [CNT_W-1:0] pos;
    logic             pos_valid;
    logic             timeout;
    logic             busy;

    modport master (
        output hsync, pad_en_n, pad_in,
        input  pos, pos_valid, timeout, busy
    );

    modport slave (
        input  hsync, pad_en_n, pad_in,
        output pos, pos_valid, timeout, busy
    );
endinterface

// File: rtl/paddle_pulse_decoder.sv
// rtl/paddle_pulse_decoder.sv - measures paddle pulse width in hsync lines; PADDLE_AVG_EN adds 4-capture averaging
module paddle_pulse_decoder #(
    parameter int CNT_W         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_LINES = 255
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    paddle_pulse_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_LINES);

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pad_s;
    logic                   hsync_q;
    logic                   hs_rise;
    logic                   en_q, en_q2;
    logic                   en_rise;
    logic [CNT_W-1:0]       count, count_d;
    logic                   to_flag, to_flag_d;
    logic [CNT_W-1:0]       cap_val;
    logic                   cap_to;
    logic                   cap_stb;

    assign pad_s   = sync_q[SYNC_STAGES-1];
    assign hs_rise = bus.hsync & ~hsync_q;
    assign en_rise = en_q & ~en_q2;

    // Window flops reset high so a release in the middle of a window waits for the next rise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            hsync_q <= 1'b0;
            en_q    <= 1'b1;
            en_q2   <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pad_in};
            hsync_q <= bus.hsync;
            en_q    <= bus.pad_en_n;
            en_q2   <= en_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            to_flag <= 1'b0;
        end else begin
            state   <= next_state;
            count   <= count_d;
            to_flag <= to_flag_d;
        end
    end

    // Pulse fall wins over a coincident line edge; timeout test precedes increment so count saturates.
    always_comb begin
        next_state = state;
        count_d    = count;
        to_flag_d  = to_flag;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    next_state = COUNT;
                    count_d    = '0;
                    to_flag_d  = 1'b0;
                end
            end
            COUNT: begin
                if (!en_q) begin
                    next_state = IDLE;
                end else if (!pad_s) begin
                    next_state = CAPTURE;
                    to_flag_d  = 1'b0;
                end else if (count == TO_VAL) begin
                    next_state = CAPTURE;
                    to_flag_d  = 1'b1;
                end else if (hs_rise) begin
                    count_d = count + 1'b1;
                end
            end
            CAPTURE: next_state = DONE;
            DONE: begin
                if (!en_q) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cap_val <= '0;
            cap_to  <= 1'b0;
            cap_stb <= 1'b0;
        end else begin
            cap_stb <= (state == CAPTURE);
            if (state == CAPTURE) begin
                cap_val <= to_flag ? TO_VAL : count;
                cap_to  <= to_flag;
            end
        end
    end

    assign bus.busy = (state == COUNT);

`ifdef PADDLE_AVG_EN
    logic [CNT_W-1:0] hist [4];
    logic [CNT_W+1:0] sum_q;
    logic [CNT_W+1:0] sum_d;
    logic [CNT_W-1:0] pos_q;
    logic             pos_valid_q;
    logic             timeout_q;

    // Running sum: drop the oldest entry, add the newest.
    assign sum_d = sum_q - {2'b00, hist[3]} + {2'b00, cap_val};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum_q       <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            pos_valid_q <= cap_stb;
            if (cap_stb) begin
                hist[0]   <= cap_val;
                hist[1]   <= hist[0];
                hist[2]   <= hist[1];
                hist[3]   <= hist[2];
                sum_q     <= sum_d;
                pos_q     <= CNT_W'(sum_d >> 2);
                timeout_q <= cap_to;
            end
        end
    end

    assign bus.pos       = pos_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.timeout   = timeout_q;
`else
    assign bus.pos       = cap_val;
    assign bus.pos_valid = cap_stb;
    assign bus.timeout   = cap_to;
`endif
endmodule
